// File: rtl/pixel_packer_if.sv
// Pixel stream input plus frame-buffer port A write bus.
// master: the packer (consumes pixels, drives port A); slave: the surrounding system.
interface pixel_packer_if #(
    parameter int unsigned ADDR_W = 17
);
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [ADDR_W-1:0] address_a;
    logic [31:0]       data_a;
    logic              wren_a;
    logic [3:0]        byteena_a;

    modport master (
        input  pix_data, pix_valid,
        output pix_ready, address_a, data_a, wren_a, byteena_a
    );

    modport slave (
        output pix_data, pix_valid,
        input  pix_ready, address_a, data_a, wren_a, byteena_a
    );
endinterface

// File: rtl/pixel_packer.sv
// Packs a frame of 8-bit pixels four-per-word (little-endian lanes) and writes
// the words to consecutive frame-buffer addresses on port A.
module pixel_packer #(
    parameter int unsigned ADDR_W       = 17,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned FRAME_PIXELS = 160000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    pixel_packer_if.master bus,
    output logic        busy,
    output logic        done,
    output logic [17:0] pix_count
);
    localparam int unsigned CNT_W  = 18;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wren_q, wren_d;
    logic [3:0]        be_q, be_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic accept_c;
    logic last_c;

    assign accept_c = (state_q == S_RUN) && bus.pix_valid;
    assign last_c   = (cnt_q == CNT_W'(FRAME_PIXELS - 1));

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            lane_q  <= 2'd0;
            ptr_q   <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            be_q    <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            be_q    <= be_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state, word assembly and registered write-port values
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = 1'b0;
        be_d    = 4'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    lane_d  = 2'd0;
                    cnt_d   = '0;
                    ptr_d   = ADDR_W'(BASE_ADDR);
                    word_d  = '0;
                end
            end
            S_RUN: begin
                if (accept_c) begin
                    // Lane 0 clears the word so unfilled lanes of a short final word read as zero
                    if (lane_q == 2'd0) begin
                        word_d = {24'd0, bus.pix_data};
                    end else begin
                        word_d[{lane_q, 3'b000} +: 8] = bus.pix_data;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_c) begin
                        wren_d  = 1'b1;
                        be_d    = 4'((5'd2 << lane_q) - 5'd1);
                        addr_d  = ptr_q;
                        data_d  = word_d;
                        state_d = S_FLUSH;
                    end else if (lane_q == 2'd3) begin
                        wren_d = 1'b1;
                        be_d   = 4'hF;
                        addr_d = ptr_q;
                        data_d = word_d;
                        ptr_d  = ptr_q + ADDR_W'(1);
                        lane_d = 2'd0;
                    end else begin
                        lane_d = lane_q + 2'd1;
                    end
                end
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_FLUSH);
        done_d = (state_d == S_DONE);
    end

    assign bus.pix_ready = (state_q == S_RUN);
    assign bus.address_a = addr_q;
    assign bus.data_a    = data_q;
    assign bus.wren_a    = wren_q;
    assign bus.byteena_a = be_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pix_count     = cnt_q;
endmodule
